// File: rtl/axi_sync_combine_pkg.sv
// Shared types and helpers for the multi-lane AXI-stream combiner:
// FSM state encoding and a saturating counter increment.
package axi_sync_combine_pkg;

  typedef enum logic {
    ST_ALIGNED = 1'b0,
    ST_DRAIN   = 1'b1
  } state_e;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_value;
    max_value = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/axi_skid_buf_n.sv
// Two-entry skid buffer: s_ready is registered (never combinational on m_ready),
// one cycle push-to-m_valid latency, full throughput while m_ready stays high.
module axi_skid_buf_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             push;
  logic             pop;

  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign m_valid = (count != 2'd0);
  assign m_data  = mem[rd_ptr];

  always_comb begin
    // NOTE: default assignment first, so no path through the case infers a latch.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the two data slots are reset as well so the merged output reads zero, not X.
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      s_ready <= 1'b0;
    end else if (clear) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      s_ready <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here; every register samples pre-edge values.
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count   <= count_next;
      s_ready <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/axi_sync_combine.sv
// Merges SIZE lock-stepped AXI-stream lanes into one wide stream, closing and realigning on
// tlast mismatch. Statistics counters are built only with AXI_SYNC_COMBINE_STATS_EN defined.
module axi_sync_combine
  import axi_sync_combine_pkg::*;
#(
  parameter int SIZE      = 2,
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [SIZE*WIDTH-1:0] i_tdata,
  input  logic [SIZE-1:0]       i_tlast,
  input  logic [SIZE-1:0]       i_tvalid,
  output logic [SIZE-1:0]       i_tready,
  output logic [SIZE*WIDTH-1:0] o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic                  err_misalign,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int DW = SIZE * WIDTH + 1;

  state_e          state;
  logic [SIZE-1:0] done;
  logic            room;
  logic            all_valid;
  logic            mismatch;
  logic            push_req;
  logic            push;
  logic [DW-1:0]   skid_out;

  assign all_valid = &i_tvalid;
  assign mismatch  = (|i_tlast) & ~(&i_tlast);
  assign push_req  = (state == ST_ALIGNED) & all_valid;
  assign push      = push_req & room;

  // Aligned lanes move together; while draining each lane runs free up to its own tlast.
  always_comb begin
    i_tready = '0;
    if (state == ST_ALIGNED) i_tready = {SIZE{room & all_valid}};
    else                     i_tready = ~done;
  end

  axi_skid_buf_n #(.WIDTH(DW)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .s_data  ({i_tlast[0] | mismatch, i_tdata}),
    .s_valid (push_req),
    .s_ready (room),
    .m_data  (skid_out),
    .m_valid (o_tvalid),
    .m_ready (o_tready)
  );

  assign o_tlast = skid_out[DW-1];
  assign o_tdata = skid_out[DW-2:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_ALIGNED;
      done         <= '0;
      err_misalign <= 1'b0;
    end else if (clear) begin
      state        <= ST_ALIGNED;
      done         <= '0;
      err_misalign <= 1'b0;
    end else begin
      err_misalign <= 1'b0;
      case (state)
        ST_ALIGNED: begin
          if (push && mismatch) begin
            state        <= ST_DRAIN;
            done         <= i_tlast;
            err_misalign <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (&done) begin
            state <= ST_ALIGNED;
            done  <= '0;
          end else begin
            done <= done | (i_tvalid & i_tready & i_tlast);
          end
        end
        default: state <= ST_ALIGNED;
      endcase
    end
  end

`ifdef AXI_SYNC_COMBINE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (clear) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (o_tvalid && o_tready && o_tlast)
        pkt_count <= CNT_WIDTH'(sat_inc(64'(pkt_count), CNT_WIDTH));
      if (push && mismatch)
        err_count <= CNT_WIDTH'(sat_inc(64'(err_count), CNT_WIDTH));
    end
  end
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_axi_sync_combine.sv
// Directed bench for axi_sync_combine (SIZE=2, WIDTH=32): cycle table plus hand-written
// backpressure, stalled-lane, reset and clear sequences.
module tb_axi_sync_combine;

`ifdef AXI_SYNC_COMBINE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [63:0] i_tdata;
  logic [1:0]  i_tlast;
  logic [1:0]  i_tvalid;
  logic [1:0]  i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        err_misalign;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_sync_combine #(.SIZE(2), .WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .i_tdata      (i_tdata),
    .i_tlast      (i_tlast),
    .i_tvalid     (i_tvalid),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .err_misalign (err_misalign),
    .pkt_count    (pkt_count),
    .err_count    (err_count)
  );

  typedef struct packed {
    logic [1:0]  iv;
    logic [1:0]  il;
    logic [63:0] id;
    logic        ordy;
    logic [1:0]  e_rdy;
    logic        e_vld;
    logic [63:0] e_data;
    logic        e_last;
    logic        e_err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] tog_beat(input int k);
    return {32'hE100_0000 | 32'(k), 32'hE000_0000 | 32'(k)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // {iv, il, id, ordy, e_rdy, e_vld, e_data, e_last, e_err}
    vecs[0]  = '{2'b11, 2'b00, 64'hB0000001_A0000001, 1'b1, 2'b11, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 2'b00, 64'hB0000002_A0000002, 1'b1, 2'b11, 1'b1, 64'hB0000001_A0000001, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 2'b00, 64'hB0000003_A0000003, 1'b1, 2'b11, 1'b1, 64'hB0000002_A0000002, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 2'b11, 64'hB0000004_A0000004, 1'b1, 2'b11, 1'b1, 64'hB0000003_A0000003, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 2'b00, 64'h0,                 1'b1, 2'b00, 1'b1, 64'hB0000004_A0000004, 1'b1, 1'b0};
    vecs[5]  = '{2'b00, 2'b00, 64'h0,                 1'b1, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 2'b00, 64'hC1000001_C0000001, 1'b1, 2'b11, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 2'b01, 64'hC1000002_C0000002, 1'b1, 2'b11, 1'b1, 64'hC1000001_C0000001, 1'b0, 1'b0};
    vecs[8]  = '{2'b11, 2'b00, 64'hC1000003_D0000001, 1'b1, 2'b10, 1'b1, 64'hC1000002_C0000002, 1'b1, 1'b1};
    vecs[9]  = '{2'b11, 2'b10, 64'hC1000004_D0000001, 1'b1, 2'b10, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 2'b00, 64'hD1000001_D0000001, 1'b1, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 2'b00, 64'hD1000001_D0000001, 1'b1, 2'b11, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[12] = '{2'b11, 2'b11, 64'hD1000002_D0000002, 1'b1, 2'b11, 1'b1, 64'hD1000001_D0000001, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 2'b00, 64'h0,                 1'b1, 2'b00, 1'b1, 64'hD1000002_D0000002, 1'b1, 1'b0};
    vecs[14] = '{2'b00, 2'b00, 64'h0,                 1'b1, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0};

    // Reset state, with both lanes offering data while reset_n is low.
    reset_n  = 1'b0;
    clear    = 1'b0;
    i_tdata  = 64'h1234_5678_9ABC_DEF0;
    i_tlast  = 2'b00;
    i_tvalid = 2'b11;
    o_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out", 128'({i_tready, o_tvalid, o_tlast, err_misalign, o_tdata}), 128'(0));
    check("reset_cnt", 128'({pkt_count, err_count}), 128'(0));
    @(negedge clk);
    reset_n  = 1'b1;
    i_tvalid = 2'b00;

    // Aligned packet, then a misaligned packet followed by a clean one.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      i_tvalid = vecs[i].iv;
      i_tlast  = vecs[i].il;
      i_tdata  = vecs[i].id;
      o_tready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d", i),
            128'({i_tready, o_tvalid, err_misalign,
                  vecs[i].e_vld ? o_tlast : 1'b0, vecs[i].e_vld ? o_tdata : 64'h0}),
            128'({vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_err,
                  vecs[i].e_last & vecs[i].e_vld, vecs[i].e_vld ? vecs[i].e_data : 64'h0}));
    end
    check("pkt_count_a", 128'(pkt_count), STATS ? 128'(3) : 128'(0));
    check("err_count_a", 128'(err_count), STATS ? 128'(1) : 128'(0));

    // One lane valid only: nothing accepted, nothing emitted.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      i_tvalid = 2'b01;
      i_tlast  = 2'b00;
      i_tdata  = 64'hDEAD_0000_BEEF_0000 | 64'(c);
      #1;
      check("partial_valid", 128'({i_tready, o_tvalid}), 128'(0));
    end

    // Continuous source against 1010... backpressure: order, hold and count.
    begin
      int  sent = 0;
      int  got = 0;
      bit  tog = 1'b1;
      bit  stalled_prev = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
        @(negedge clk);
        i_tvalid = (sent < 8) ? 2'b11 : 2'b00;
        i_tdata  = tog_beat(sent);
        i_tlast  = (sent == 7) ? 2'b11 : 2'b00;
        o_tready = tog;
        tog      = ~tog;
        #1;
        if (stalled_prev) check("tog_hold", 128'(o_tvalid), 128'(1));
        if (o_tvalid) check("tog_data", 128'({o_tlast, o_tdata}), 128'({got == 7, tog_beat(got)}));
        stalled_prev = o_tvalid & ~o_tready;
        if (o_tvalid && o_tready) got++;
        if (&(i_tvalid & i_tready)) sent++;
      end
      check("tog_count", 128'(got), 128'(8));
      @(negedge clk);
      i_tvalid = 2'b00;
      o_tready = 1'b1;
      #1;
      check("tog_drained", 128'(o_tvalid), 128'(0));
      check("pkt_count_b", 128'(pkt_count), STATS ? 128'(4) : 128'(0));
    end

    // Reset mid-packet with beats held in the output stage.
    o_tready = 1'b0;
    @(negedge clk);
    i_tvalid = 2'b11;
    i_tlast  = 2'b00;
    i_tdata  = 64'hF1000001_F0000001;
    @(negedge clk);
    i_tdata  = 64'hF1000002_F0000002;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_out", 128'({i_tready, o_tvalid, o_tlast, err_misalign, o_tdata}), 128'(0));
    check("rst_mid_cnt", 128'({pkt_count, err_count}), 128'(0));
    @(negedge clk);
    reset_n  = 1'b1;
    i_tvalid = 2'b00;
    o_tready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("rst_idle", 128'(o_tvalid), 128'(0));
    end

    // Clear while draining after a mismatch.
    @(negedge clk);
    o_tready = 1'b0;
    i_tvalid = 2'b11;
    i_tlast  = 2'b01;
    i_tdata  = 64'h51000001_50000001;
    #1;
    check("clr_push", 128'(i_tready), 128'(2'b11));
    @(negedge clk);
    clear    = 1'b1;
    i_tlast  = 2'b00;
    i_tdata  = 64'h51000002_50000002;
    #1;
    check("clr_drain", 128'({i_tready, o_tvalid, o_tlast, err_misalign, o_tdata}),
          128'({2'b10, 1'b1, 1'b1, 1'b1, 64'h51000001_50000001}));
    check("clr_errcnt", 128'(err_count), STATS ? 128'(1) : 128'(0));
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_after", 128'({i_tready, o_tvalid, o_tlast, err_misalign, o_tdata}), 128'(0));
    check("clr_cnt", 128'({pkt_count, err_count}), 128'(0));
    @(negedge clk);
    o_tready = 1'b1;
    i_tlast  = 2'b11;
    i_tdata  = 64'h61000001_60000001;
    #1;
    check("clr_aligned", 128'({i_tready, o_tvalid}), 128'({2'b11, 1'b0}));
    @(negedge clk);
    i_tvalid = 2'b00;
    i_tlast  = 2'b00;
    #1;
    check("clr_beat", 128'({o_tvalid, o_tlast, o_tdata}), 128'({1'b1, 1'b1, 64'h61000001_60000001}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
